// File: rtl/dmem_bus_if.sv
// dmem_bus_if
//   Data-memory bus interface behind the MEM-stage memory controller. It turns
//   the controller's combinational access strobe into a registered req/ack bus
//   transaction. While the transaction is outstanding it stalls the pipeline.
//   It hands the read word back to the controller, and it reports misaligned
//   accesses, slave errors and timeouts as a one-cycle fault pulse.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   mem_op_as_      active-low access strobe from the memory controller
//   rw              direction (READ = 1, WRITE = 0)
//   addr_to_mem     word address
//   wr_data         store data
//   miss_align      misaligned-access flag
//   flush           kill for the instruction currently in MEM
//   mem_data        registered read word returned to the controller
//   mem_busy        pipeline stall request (combinational)
//   bus_req/rw/addr/wdata  registered bus request
//   bus_ack, bus_err, bus_rdata  slave response (err/rdata valid with ack)
//   bus_fault       one-cycle fault pulse
//   fault_addr      address of the last faulting access
module dmem_bus_if #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_op_as_,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr_to_mem,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              miss_align,
  input  logic              flush,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_busy,
  output logic              bus_req,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic              bus_err,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_fault,
  output logic [ADDR_W-1:0] fault_addr
);

  localparam logic READ = 1'b1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // The last REQ cycle before abort: the counter starts at 0 on entry, so
  // the timeout fires in the TIMEOUT-th REQ cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             kill;
  logic             new_req;
  logic             abort;

  assign new_req = ~mem_op_as_ & ~flush;
  // A flush seen in any REQ cycle, including the one that completes, means
  // the result is discarded instead of being reported to the pipeline.
  assign abort   = kill | flush;

  // The stall is raised in the accept cycle itself, so the pipeline does not
  // advance past an instruction whose access has only just been issued.
  always_comb begin
    mem_busy = 1'b0;
    if (state == REQ)
      mem_busy = 1'b1;
    else if (state == IDLE && new_req)
      mem_busy = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      kill       <= 1'b0;
      bus_req    <= 1'b0;
      bus_rw     <= READ;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      mem_data   <= '0;
      bus_fault  <= 1'b0;
      fault_addr <= '0;
    end else begin
      bus_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (new_req) begin
            if (miss_align) begin
              fault_addr <= addr_to_mem;
              bus_fault  <= 1'b1;
              state      <= ERR;
            end else begin
              bus_addr  <= addr_to_mem;
              bus_rw    <= rw;
              bus_wdata <= wr_data;
              bus_req   <= 1'b1;
              cnt       <= '0;
              kill      <= 1'b0;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          cnt <= cnt + CNT_W'(1);
          // The bus cannot withdraw a request, so a flush only marks the
          // transaction to be dropped when it finishes.
          if (flush)
            kill <= 1'b1;
          if (bus_ack && !bus_err) begin
            bus_req <= 1'b0;
            if (bus_rw == READ)
              mem_data <= bus_rdata;
            state <= abort ? IDLE : DONE;
          end else if (bus_ack || cnt == CNT_LAST) begin
            bus_req    <= 1'b0;
            fault_addr <= bus_addr;
            if (abort) begin
              state <= IDLE;
            end else begin
              bus_fault <= 1'b1;
              state     <= ERR;
            end
          end
        end
        // The strobe is still low here for the instruction that just
        // completed; it must not be accepted a second time.
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_if.sv
module tb_dmem_bus_if;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_op_as_;
  logic        rw;
  logic [29:0] addr_to_mem;
  logic [31:0] wr_data;
  logic        miss_align;
  logic        flush;
  logic [31:0] mem_data;
  logic        mem_busy;
  logic        bus_req;
  logic        bus_rw;
  logic [29:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic        bus_err;
  logic [31:0] bus_rdata;
  logic        bus_fault;
  logic [29:0] fault_addr;

  int checks = 0;
  int errors = 0;

  dmem_bus_if #(.ADDR_W(30), .DATA_W(32), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .mem_op_as_(mem_op_as_), .rw(rw),
    .addr_to_mem(addr_to_mem), .wr_data(wr_data), .miss_align(miss_align),
    .flush(flush), .mem_data(mem_data), .mem_busy(mem_busy),
    .bus_req(bus_req), .bus_rw(bus_rw), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_err(bus_err),
    .bus_rdata(bus_rdata), .bus_fault(bus_fault), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  // One transaction: stimulus plus the results it must produce.
  // waits = number of REQ cycles before ack (-1: slave never acks).
  typedef struct {
    logic        rw;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic        miss;
    int          waits;
    logic        err;
    logic [31:0] rdata;
    logic        flush_in_req;
    int          exp_req;
    int          exp_busy;
    int          exp_fault;
    logic [31:0] exp_mem_data;
    logic [29:0] exp_fault_addr;
  } vec_t;

  vec_t exp_q[$];
  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_op_as_ = 1'b1;
    miss_align = 1'b0;
    flush      = 1'b0;
    bus_ack    = 1'b0;
    bus_err    = 1'b0;
    bus_rdata  = '0;
  endtask

  task automatic run_txn(input vec_t v);
    vec_t        e;
    int          req_idx  = 0;
    int          req_n    = 0;
    int          busy_n   = 0;
    int          fault_n  = 0;
    int          unstable = 0;
    int          c        = 0;
    logic        done     = 1'b0;
    logic        killed   = 1'b0;
    logic [31:0] md       = '0;
    logic [29:0] fa       = '0;
    exp_q.push_back(v);
    mem_op_as_  = 1'b0;
    rw          = v.rw;
    addr_to_mem = v.addr;
    wr_data     = v.wdata;
    miss_align  = v.miss;
    flush       = 1'b0;
    while (!done && c < 400) begin
      bus_ack   = 1'b0;
      bus_err   = 1'b0;
      bus_rdata = '0;
      flush     = 1'b0;
      if (bus_req) begin
        if (v.waits >= 0 && req_idx == v.waits) begin
          bus_ack   = 1'b1;
          bus_err   = v.err;
          bus_rdata = v.rdata;
        end
        if (v.flush_in_req && req_idx == 0) begin
          flush  = 1'b1;
          killed = 1'b1;
        end
        req_idx++;
      end
      #1;
      if (mem_busy) busy_n++;
      if (bus_req) begin
        req_n++;
        if (bus_addr !== v.addr || bus_rw !== v.rw || bus_wdata !== v.wdata)
          unstable++;
      end
      if (bus_fault) begin
        fault_n++;
        fa = fault_addr;
      end
      if (!mem_busy && c > 0) begin
        done = 1'b1;
        md   = mem_data;
      end
      tick();
      if (killed) mem_op_as_ = 1'b1;
      c++;
    end
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      #1;
      if (mem_busy) busy_n++;
      if (bus_req) req_n++;
      if (bus_fault) fault_n++;
      tick();
    end
    e = exp_q.pop_front();
    check($sformatf("completed@%0h", e.addr), 64'(done), 64'(1'b1));
    check($sformatf("req_cycles@%0h", e.addr), 64'(req_n), 64'(e.exp_req));
    check($sformatf("busy_cycles@%0h", e.addr), 64'(busy_n), 64'(e.exp_busy));
    check($sformatf("fault_pulses@%0h", e.addr), 64'(fault_n), 64'(e.exp_fault));
    check($sformatf("bus_stable@%0h", e.addr), 64'(unstable), 64'(0));
    check($sformatf("mem_data@%0h", e.addr), 64'(md), 64'(e.exp_mem_data));
    if (e.exp_fault != 0)
      check($sformatf("fault_addr@%0h", e.addr), 64'(fa), 64'(e.exp_fault_addr));
  endtask

  initial begin
    vec_t v;
    //          rw  addr           wdata          miss  waits err   rdata          flush req  busy flt mem_data       fault_addr
    vecs[0] = '{RD, 30'h10,        32'h0,         1'b0, 0,    1'b0, 32'hDEADBEEF,  1'b0, 1,   2,   0,  32'hDEADBEEF,  30'h0};
    vecs[1] = '{WR, 30'h20,        32'h12345678,  1'b0, 3,    1'b0, 32'h0,         1'b0, 4,   5,   0,  32'hDEADBEEF,  30'h0};
    vecs[2] = '{RD, 30'h3,         32'h0,         1'b1, 0,    1'b0, 32'h0,         1'b0, 0,   1,   1,  32'hDEADBEEF,  30'h3};
    vecs[3] = '{RD, 30'h44,        32'h0,         1'b0, -1,   1'b0, 32'h0,         1'b0, 255, 256, 1,  32'hDEADBEEF,  30'h44};
    vecs[4] = '{RD, 30'h55,        32'h0,         1'b0, 1,    1'b1, 32'hBAD0BAD0,  1'b0, 2,   3,   1,  32'hDEADBEEF,  30'h55};
    vecs[5] = '{RD, 30'h66,        32'h0,         1'b0, 2,    1'b1, 32'hBAD0BAD0,  1'b1, 3,   4,   0,  32'hDEADBEEF,  30'h0};
    vecs[6] = '{RD, 30'h3FFFFFFF,  32'h0,         1'b0, 1,    1'b0, 32'hA5A55A5A,  1'b0, 2,   3,   0,  32'hA5A55A5A,  30'h0};
    vecs[7] = '{WR, 30'h0,         32'hFFFFFFFF,  1'b0, 0,    1'b0, 32'h0,         1'b0, 1,   2,   0,  32'hA5A55A5A,  30'h0};
    vecs[8] = '{RD, 30'h77,        32'h0,         1'b0, 254,  1'b0, 32'h0BADF00D,  1'b0, 255, 256, 0,  32'h0BADF00D,  30'h0};

    idle_inputs();
    rw          = RD;
    addr_to_mem = '0;
    wr_data     = '0;
    rst         = 1'b1;
    tick();
    tick();
    check("rst_bus_req", 64'(bus_req), 64'(1'b0));
    check("rst_bus_rw", 64'(bus_rw), 64'(RD));
    check("rst_bus_addr", 64'(bus_addr), 64'(30'h0));
    check("rst_bus_wdata", 64'(bus_wdata), 64'(32'h0));
    check("rst_mem_data", 64'(mem_data), 64'(32'h0));
    check("rst_bus_fault", 64'(bus_fault), 64'(1'b0));
    check("rst_fault_addr", 64'(fault_addr), 64'(30'h0));
    check("rst_mem_busy", 64'(mem_busy), 64'(1'b0));
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++)
      run_txn(vecs[i]);

    // A flushed strobe in IDLE is not a request.
    mem_op_as_  = 1'b0;
    flush       = 1'b1;
    addr_to_mem = 30'h99;
    #1;
    check("flush_idle_busy", 64'(mem_busy), 64'(1'b0));
    tick();
    check("flush_idle_req", 64'(bus_req), 64'(1'b0));
    idle_inputs();
    tick();

    // Stray ack/err outside REQ is ignored.
    bus_ack   = 1'b1;
    bus_err   = 1'b1;
    bus_rdata = 32'hFFFFFFFF;
    tick();
    tick();
    check("stray_ack_fault", 64'(bus_fault), 64'(1'b0));
    check("stray_ack_mem_data", 64'(mem_data), 64'(32'h0BADF00D));
    check("stray_ack_req", 64'(bus_req), 64'(1'b0));
    idle_inputs();
    tick();

    // Reset while a request is outstanding.
    mem_op_as_  = 1'b0;
    rw          = WR;
    addr_to_mem = 30'h88;
    wr_data     = 32'hCAFEF00D;
    tick();
    check("pre_rst_req", 64'(bus_req), 64'(1'b1));
    mem_op_as_ = 1'b1;
    rst        = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_req", 64'(bus_req), 64'(1'b0));
    check("mid_rst_busy", 64'(mem_busy), 64'(1'b0));
    check("mid_rst_rw", 64'(bus_rw), 64'(RD));
    check("mid_rst_addr", 64'(bus_addr), 64'(30'h0));
    check("mid_rst_wdata", 64'(bus_wdata), 64'(32'h0));
    check("mid_rst_mem_data", 64'(mem_data), 64'(32'h0));
    check("mid_rst_fault_addr", 64'(fault_addr), 64'(30'h0));
    check("mid_rst_fault", 64'(bus_fault), 64'(1'b0));
    tick();
    v = '{RD, 30'h10, 32'h0, 1'b0, 0, 1'b0, 32'h13579BDF, 1'b0, 1, 2, 0, 32'h13579BDF, 30'h0};
    run_txn(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_bus_if.md
Name: dmem_bus_if

Overview:
- Data-memory bus interface directly downstream of the MEM-stage memory controller.
- Turns the controller's combinational request (active-low strobe, rw, word address, write data, misalign flag) into a registered req/ack bus transaction.
- Stalls the pipeline while the transaction is outstanding and returns the read word to the controller's mem_data input.
- Reports misaligned accesses, bus errors and timeouts as one-cycle faults.

Parameters:
ADDR_W, 30, word-address width (matches the word address bus)
DATA_W, 32, data width (matches the word width)
TIMEOUT, 255, max cycles in REQ without bus_ack before abort; counter width = clog2(TIMEOUT+1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
mem_op_as_  in  1  active-low access strobe from the memory controller
rw  in  1  `READ / `WRITE from the memory controller
addr_to_mem  in  ADDR_W  word address from the memory controller
wr_data  in  DATA_W  store data from the memory controller
miss_align  in  1  misaligned-access flag from the memory controller
flush  in  1  pipeline kill for the MEM-stage instruction
mem_data  out  DATA_W  registered read word, returned to the memory controller
mem_busy  out  1  pipeline stall request
bus_req  out  1  bus request, registered
bus_rw  out  1  bus direction, registered
bus_addr  out  ADDR_W  bus word address, registered
bus_wdata  out  DATA_W  bus write data, registered
bus_ack  in  1  slave completion
bus_err  in  1  slave error, sampled only with bus_ack
bus_rdata  in  DATA_W  slave read data, valid with bus_ack
bus_fault  out  1  one-cycle fault pulse, registered
fault_addr  out  ADDR_W  address of the last faulting access

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state IDLE, timeout counter 0, kill 0, bus_req 0, bus_rw `READ, bus_addr 0, bus_wdata 0, mem_data 0, bus_fault 0, fault_addr 0.
- Reset mid-transaction: bus_req drops at that edge; the slave must tolerate an abandoned request.
- States: IDLE, REQ, DONE, ERR.
- Request condition: new = (mem_op_as_==0) & ~flush.
- IDLE, new & ~miss_align:
  - latch bus_addr, bus_rw, bus_wdata; set bus_req=1; counter=0; kill=0; go REQ.
  - mem_busy=1 combinationally in this same cycle.
- IDLE, new & miss_align:
  - no bus activity; go ERR; fault_addr<=addr_to_mem.
  - mem_busy=1 in this cycle.
- REQ:
  - mem_busy=1; bus_req, bus_addr, bus_rw, bus_wdata held stable until ack.
  - counter increments each cycle.
  - flush while in REQ sets kill=1; the transaction still runs to ack or timeout (bus protocol forbids withdrawal).
- REQ, bus_ack & ~bus_err:
  - bus_req<=0.
  - on a read, mem_data<=bus_rdata; on a write, mem_data unchanged.
  - go DONE, or IDLE if kill or flush.
- REQ, bus_ack & bus_err: bus_req<=0; fault_addr<=bus_addr; go ERR, or IDLE if kill or flush.
- REQ, no ack and counter==TIMEOUT-1: bus_req<=0; fault_addr<=bus_addr; go ERR, or IDLE if kill or flush. Timeout takes effect on the TIMEOUT-th REQ cycle.
- DONE:
  - mem_busy=0; mem_data valid; pipeline advances at this edge; go IDLE.
  - A request seen in DONE is the completed instruction and is not re-accepted.
- ERR:
  - mem_busy=0; bus_fault=1 for exactly this cycle; go IDLE.
  - bus_fault is registered, so it is high in the cycle after the transition into ERR.
- Otherwise mem_busy=0.
- Latency, zero-wait slave (ack in the first REQ cycle):
  - accept at cycle 0, REQ at cycle 1, DONE at cycle 2.
  - mem_busy high for 2 cycles; 3 cycles total.
  - Each wait state adds 1 cycle.
- bus_ack outside REQ is ignored.
- mem_data holds its last value between reads.

Test Plan:
- Read with zero-wait slave returning 0xDEADBEEF at addr 0x10 -> bus_req high 1 cycle with bus_addr=0x10, bus_rw=`READ; mem_busy high 2 cycles; mem_data=0xDEADBEEF in DONE.
- Write of 0x12345678 with ack after 3 wait states -> bus_req/bus_wdata stable for 4 cycles; mem_busy high 5 cycles; mem_data unchanged; no fault.
- Misaligned access, addr_to_mem=0x3 with miss_align=1 -> bus_req never asserts; bus_fault pulses 1 cycle; fault_addr=0x3; mem_busy high 1 cycle.
- Slave never acks, TIMEOUT=255 -> bus_req high exactly 255 cycles, then drops; bus_fault 1-cycle pulse; fault_addr=bus_addr; FSM returns to IDLE.
- bus_ack with bus_err on a read -> mem_data unchanged; bus_fault pulse.
- Same bus_err case with flush asserted in REQ -> no fault, no DONE, mem_busy held until ack.
- rst asserted in REQ with bus_req high -> next cycle bus_req=0, mem_busy=0, all outputs at reset values; a new read after reset completes normally.
